// File: rtl/rand_pulse_gen_mc_pkg.sv
// Shared types and seed helper for the random pulse generator.
// Optional seed loading is enabled by RPG_SEED_LOAD_EN.
package rand_pulse_pkg;

  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLD
  } rpg_state_t;

  function automatic logic [15:0] seed_for_ch(
    input logic [15:0] base,
    input int unsigned i
  );
    logic [31:0] p;
    logic [15:0] s;
    p = 32'h1D2F * (i + 32'd1);
    s = base ^ p[15:0];
    return (s == 16'h0) ? 16'h1 : s;
  endfunction

endpackage

// File: rtl/rand_pulse_gen_mc_if.sv
// Pin-level bundle between encoder pins and the pulse bus.
// Seed load signals exist only with RPG_SEED_LOAD_EN.
interface rand_pulse_gen_mc_if #(
  parameter int NUM_CH = 4,
  parameter int RATE_W = 4
`ifdef RPG_SEED_LOAD_EN
  , parameter int LFSR_W = 16
`endif
);
  logic              ena;
  logic              enc_a;
  logic              enc_b;
  logic [NUM_CH-1:0] pulse;
  logic [RATE_W-1:0] rate;
  logic [7:0]        fire_cnt;
`ifdef RPG_SEED_LOAD_EN
  logic              seed_we;
  logic [2:0]        seed_ch;
  logic [LFSR_W-1:0] seed_data;

  modport master (
    output ena, enc_a, enc_b,
    output seed_we, seed_ch, seed_data,
    input  pulse, rate, fire_cnt
  );
  modport slave (
    input  ena, enc_a, enc_b,
    input  seed_we, seed_ch, seed_data,
    output pulse, rate, fire_cnt
  );
`else
  modport master (
    output ena, enc_a, enc_b,
    input  pulse, rate, fire_cnt
  );
  modport slave (
    input  ena, enc_a, enc_b,
    output pulse, rate, fire_cnt
  );
`endif
endinterface

// File: rtl/rand_pulse_gen_mc_lfsr.sv
// Right-shifting Galois LFSR with load-over-advance priority.
// A zero load value is replaced by 1 to avoid the lock-up state.
module rpg_lfsr #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = '0,
  parameter logic [LFSR_W-1:0] SEED_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] nxt;

  assign nxt = q[0] ? ((q >> 1) ^ TAPS) : (q >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= SEED_INIT;
    end else if (load) begin
      q <= (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (adv) begin
      q <= nxt;
    end
  end
endmodule

// File: rtl/rand_pulse_gen_mc.sv
// Multi-channel random pulse generator with encoder rate control.
// Define RPG_SEED_LOAD_EN to add runtime LFSR seed loading.
module rand_pulse_gen_mc
  import rand_pulse_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          LFSR_W    = 16,
  parameter int          RATE_W    = 4,
  parameter int          PULSE_LEN = 1,
  parameter int          HOLDOFF   = 2,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic                clk,
  input logic                rst_n,
  rand_pulse_gen_mc_if.slave bus
);
  localparam int CMAX  = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [RATE_W-1:0] RMAX = '1;
  localparam logic [CNT_W-1:0] PL_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HO_LD =
    CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic [2:0]        a_sh;
  logic [1:0]        b_sh;
  logic              a_rise;
  logic [RATE_W-1:0] rate_q;
  logic [NUM_CH-1:0] pulse_q;
  logic [7:0]        fire_q;

  logic [NUM_CH-1:0][LFSR_W-1:0] lfsr_q;
  logic [NUM_CH-1:0]             fire;
  logic [NUM_CH-1:0]             start;
  logic [NUM_CH-1:0]             pulse_n;
  rpg_state_t [NUM_CH-1:0]       st;
  rpg_state_t [NUM_CH-1:0]       st_n;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  cnt_n;
  logic [7:0]                    pop;

  // two sync stages, third stage only for rising-edge detect
  assign a_rise = a_sh[1] & ~a_sh[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      rate_q <= '0;
    end else begin
      a_sh <= {a_sh[1:0], bus.enc_a};
      b_sh <= {b_sh[0], bus.enc_b};
      if (a_rise && !b_sh[1] && rate_q != RMAX)
        rate_q <= rate_q + 1'b1;
      else if (a_rise && b_sh[1] && rate_q != '0)
        rate_q <= rate_q - 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic              ld;
    logic [LFSR_W-1:0] ldv;
`ifdef RPG_SEED_LOAD_EN
    assign ld  = bus.seed_we && (bus.seed_ch == 3'(i));
    assign ldv = bus.seed_data;
`else
    assign ld  = 1'b0;
    assign ldv = '0;
`endif
    rpg_lfsr #(
      .LFSR_W    (LFSR_W),
      .TAPS      (LFSR_W'(LFSR16_TAPS)),
      .SEED_INIT (LFSR_W'(seed_for_ch(SEED, i)))
    ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (bus.ena),
      .load     (ld),
      .load_val (ldv),
      .q        (lfsr_q[i])
    );
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    start   = '0;
    fire    = '0;
    pulse_n = '0;
    pop     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i] = lfsr_q[i][RATE_W-1:0] < rate_q;
      if (!bus.ena) begin
        st_n[i]  = ST_IDLE;
        cnt_n[i] = '0;
      end else begin
        unique case (1'b1)
          (st[i] == ST_IDLE): begin
            if (fire[i]) begin
              st_n[i]  = ST_PULSE;
              cnt_n[i] = PL_LD;
              start[i] = 1'b1;
            end
          end
          (st[i] == ST_PULSE): begin
            if (cnt[i] != '0) begin
              cnt_n[i] = cnt[i] - 1'b1;
            end else if (HOLDOFF == 0) begin
              st_n[i] = ST_IDLE;
            end else begin
              st_n[i]  = ST_HOLD;
              cnt_n[i] = HO_LD;
            end
          end
          (st[i] == ST_HOLD): begin
            if (cnt[i] != '0)
              cnt_n[i] = cnt[i] - 1'b1;
            else
              st_n[i] = ST_IDLE;
          end
          default: begin
            st_n[i]  = ST_IDLE;
            cnt_n[i] = '0;
          end
        endcase
      end
      pulse_n[i] = (st_n[i] == ST_PULSE);
      pop        = pop + 8'(start[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]  <= ST_IDLE;
        cnt[i] <= '0;
      end
      pulse_q <= '0;
      fire_q  <= '0;
    end else begin
      st      <= st_n;
      cnt     <= cnt_n;
      pulse_q <= pulse_n;
      fire_q  <= fire_q + pop;
    end
  end

  assign bus.pulse    = pulse_q;
  assign bus.rate     = rate_q;
  assign bus.fire_cnt = fire_q;
endmodule

// File: tb/tb_rand_pulse_gen_mc.sv
// Scoreboard bench: two DUTs (3/2 and 1/0 pulse/holdoff) vs a
// cycle model, plus hand-computed encoder and reset vectors.
module tb_rand_pulse_gen_mc;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  always #5 clk = ~clk;

  rand_pulse_gen_mc_if #(.NUM_CH(4), .RATE_W(4)) bus0 ();
  rand_pulse_gen_mc_if #(.NUM_CH(4), .RATE_W(4)) bus1 ();

  assign bus0.ena   = ena;
  assign bus0.enc_a = enc_a;
  assign bus0.enc_b = enc_b;
  assign bus1.ena   = ena;
  assign bus1.enc_a = enc_a;
  assign bus1.enc_b = enc_b;
`ifdef RPG_SEED_LOAD_EN
  assign bus0.seed_we   = 1'b0;
  assign bus0.seed_ch   = 3'd0;
  assign bus0.seed_data = 16'h0;
  assign bus1.seed_we   = 1'b0;
  assign bus1.seed_ch   = 3'd0;
  assign bus1.seed_data = 16'h0;
`endif

  rand_pulse_gen_mc #(
    .NUM_CH(4), .LFSR_W(16), .RATE_W(4),
    .PULSE_LEN(3), .HOLDOFF(2), .SEED(16'hACE1)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  rand_pulse_gen_mc #(
    .NUM_CH(4), .LFSR_W(16), .RATE_W(4),
    .PULSE_LEN(1), .HOLDOFF(0), .SEED(16'hACE1)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  typedef struct {
    logic [3:0] p0;
    logic [3:0] p1;
    logic [3:0] r;
    logic [7:0] f0;
    logic [7:0] f1;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int fails   = 0;

  // seeds worked by hand: ACE1 ^ 1D2F*(i+1)
  logic [15:0] seeds [4] = '{16'hB1CE, 16'h96BF, 16'hFB6C, 16'hD85D};
  int pl [2] = '{3, 1};
  int ho [2] = '{2, 0};

  logic [15:0] m_lfsr [2][4];
  int          m_ph   [2][4];
  int          m_left [2][4];
  int          m_fc   [2];
  logic [2:0]  m_a;
  logic [1:0]  m_b;
  int          m_rate;

  logic shape_on = 1'b0;
  logic stat_on  = 1'b0;
  int   hi_run [4];
  int   lo_run [4];
  logic seen   [4];
  logic [3:0] prev0, prev_d1, prev_e1;
  int   d1_rise [4];
  int   e1_rise [4];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h @%0t", name, act, want, $time);
    end
  endtask

  always @(posedge clk) begin : model
    exp_t e;
    logic rise, bl;
    int   r0;
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_rate = 0;
      for (int k = 0; k < 2; k++) begin
        m_fc[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_lfsr[k][c] = seeds[c];
          m_ph[k][c]   = 0;
          m_left[k][c] = 0;
        end
      end
    end else begin
      rise = m_a[1] && !m_a[2];
      bl   = m_b[1];
      r0   = m_rate;
      m_a  = {m_a[1:0], enc_a};
      m_b  = {m_b[0], enc_b};
      if (rise && !bl && m_rate < 15) m_rate++;
      else if (rise && bl && m_rate > 0) m_rate--;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) begin
          if (!ena) begin
            m_ph[k][c] = 0;
            m_left[k][c] = 0;
          end else begin
            case (m_ph[k][c])
              0: if (int'(m_lfsr[k][c][3:0]) < r0) begin
                m_ph[k][c] = 1;
                m_left[k][c] = pl[k];
                m_fc[k] = (m_fc[k] + 1) % 256;
              end
              1: begin
                m_left[k][c]--;
                if (m_left[k][c] == 0) begin
                  if (ho[k] > 0) begin
                    m_ph[k][c] = 2;
                    m_left[k][c] = ho[k];
                  end else m_ph[k][c] = 0;
                end
              end
              default: begin
                m_left[k][c]--;
                if (m_left[k][c] == 0) m_ph[k][c] = 0;
              end
            endcase
            if (m_lfsr[k][c][0])
              m_lfsr[k][c] = (m_lfsr[k][c] >> 1) ^ 16'hB400;
            else
              m_lfsr[k][c] = m_lfsr[k][c] >> 1;
          end
        end
    end
    for (int c = 0; c < 4; c++) begin
      e.p0[c] = (m_ph[0][c] == 1);
      e.p1[c] = (m_ph[1][c] == 1);
    end
    e.r  = 4'(m_rate);
    e.f0 = 8'(m_fc[0]);
    e.f1 = 8'(m_fc[1]);
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("cyc_dut0", {16'h0, bus0.pulse, bus0.rate, bus0.fire_cnt},
            {16'h0, e.p0, e.r, e.f0});
      check("cyc_dut1", {16'h0, bus1.pulse, bus1.rate, bus1.fire_cnt},
            {16'h0, e.p1, e.r, e.f1});
      for (int c = 0; c < 4; c++) begin
        if (!shape_on) begin
          seen[c] = 1'b0; hi_run[c] = 0; lo_run[c] = 0;
        end else if (bus0.pulse[c]) begin
          if (!prev0[c]) begin
            if (seen[c]) check("low_gap_ge2", 32'(lo_run[c] >= 2), 32'd1);
            hi_run[c] = 1;
            seen[c]   = 1'b1;
          end else hi_run[c]++;
        end else begin
          if (prev0[c]) begin
            check("high_run_len", 32'(hi_run[c]), 32'd3);
            lo_run[c] = 1;
          end else lo_run[c]++;
        end
        if (stat_on) begin
          if (bus1.pulse[c] && !prev_d1[c]) d1_rise[c]++;
          if (e.p1[c] && !prev_e1[c]) e1_rise[c]++;
        end
      end
      prev0   = bus0.pulse;
      prev_d1 = bus1.pulse;
      prev_e1 = e.p1;
    end
  end

  task automatic enc_edge(input logic b);
    enc_b = b;
    repeat (2) @(negedge clk);
    enc_a = 1'b1;
    repeat (8) @(negedge clk);
    enc_a = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic any_ph(input int k, input int v);
    logic r = 1'b0;
    for (int c = 0; c < 4; c++) if (m_ph[k][c] == v) r = 1'b1;
    return r;
  endfunction

  initial begin
    int total;
    int n;
    for (int c = 0; c < 4; c++) begin
      d1_rise[c] = 0; e1_rise[c] = 0;
    end
    prev0 = '0; prev_d1 = '0; prev_e1 = '0;
    // reset state and quiet run
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", 32'({bus1.pulse, bus0.pulse}), 32'd0);
    check("rst_rate", 32'(bus0.rate), 32'd0);
    check("rst_fcnt", 32'(bus0.fire_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("quiet_pulse", 32'({bus1.pulse, bus0.pulse}), 32'd0);
    // encoder up, saturating at 15
    for (int i = 0; i < 20; i++) begin
      enc_edge(1'b0);
      check("rate_up", 32'(bus0.rate), (i < 15) ? 32'(i + 1) : 32'd15);
    end
    // encoder down to 0, then one step up
    for (int i = 0; i < 17; i++) begin
      enc_edge(1'b1);
      check("rate_dn", 32'(bus1.rate), (i < 15) ? 32'(14 - i) : 32'd0);
    end
    enc_edge(1'b0);
    check("rate_back", 32'(bus0.rate), 32'd1);
    // pulse shape at rate 15
    do_reset();
    @(posedge clk);
    shape_on = 1'b1;
    for (int i = 0; i < 15; i++) enc_edge(1'b0);
    check("rate_max", 32'(bus0.rate), 32'd15);
    repeat (2000) @(negedge clk);
    @(posedge clk);
    shape_on = 1'b0;
    // statistics at rate 8 on the 1/0 instance
    @(negedge clk);
    do_reset();
    @(posedge clk);
    stat_on = 1'b1;
    for (int i = 0; i < 8; i++) enc_edge(1'b0);
    check("rate_8", 32'(bus1.rate), 32'd8);
    repeat (65536) @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    stat_on = 1'b0;
    @(negedge clk);
    total = 0;
    for (int c = 0; c < 4; c++) begin
      check("stat_ch", 32'(d1_rise[c]), 32'(e1_rise[c]));
      total += e1_rise[c];
    end
    check("stat_fcnt", 32'(bus1.fire_cnt), 32'(total % 256));
    // ena drop while a channel is in PULSE
    ena = 1'b1;
    n = 0;
    while (!any_ph(0, 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!any_ph(0, 1)) begin
      fails++;
      $display("FAIL wait_pulse: no PULSE within 200 cycles");
    end
    ena = 1'b0;
    @(negedge clk);
    check("ena_drop", 32'({bus1.pulse, bus0.pulse}), 32'd0);
    repeat (4) @(negedge clk);
    ena = 1'b1;
    n = 0;
    while (!any_ph(0, 2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!any_ph(0, 2)) begin
      fails++;
      $display("FAIL wait_hold: no HOLD within 500 cycles");
    end
    // reset while holding
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_pulse", 32'(bus0.pulse), 32'd0);
    check("rst2_rate", 32'(bus0.rate), 32'd0);
    check("rst2_fcnt", 32'(bus0.fire_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
